// File: rtl/wash_pkg.sv
// Shared phase encoding and wash-program table for the wash-cycle sequencer.
package wash_pkg;

    typedef enum logic [3:0] {
        OFF    = 4'd0,
        IDLE   = 4'd1,
        FILL1  = 4'd2,
        WASH   = 4'd3,
        DRAIN1 = 4'd4,
        FILL2  = 4'd5,
        RINSE  = 4'd6,
        DRAIN2 = 4'd7,
        SPIN   = 4'd8,
        DONE   = 4'd9,
        PAUSE  = 4'd10
    } phase_t;

    // Per-program fill target (L), wash (W), rinse (R) and spin (S) lengths in ticks.
    localparam logic [5:0] P0_L = 6'd4, P0_W = 6'd9,  P0_R = 6'd6, P0_S = 6'd4;
    localparam logic [5:0] P1_L = 6'd3, P1_W = 6'd5,  P1_R = 6'd3, P1_S = 6'd3;
    localparam logic [5:0] P2_L = 6'd6, P2_W = 6'd15, P2_R = 6'd9, P2_S = 6'd6;
    localparam logic [5:0] P3_L = 6'd0, P3_W = 6'd0,  P3_R = 6'd0, P3_S = 6'd5;

    localparam logic [5:0] P0_T = 6'(4 * P0_L + P0_W + P0_R + P0_S);
    localparam logic [5:0] P1_T = 6'(4 * P1_L + P1_W + P1_R + P1_S);
    localparam logic [5:0] P2_T = 6'(4 * P2_L + P2_W + P2_R + P2_S);
    localparam logic [5:0] P3_T = 6'(4 * P3_L + P3_W + P3_R + P3_S);

    function automatic logic [5:0] prog_total(input logic [1:0] prog);
        case (prog)
            2'd0:    return P0_T;
            2'd1:    return P1_T;
            2'd2:    return P2_T;
            default: return P3_T;
        endcase
    endfunction

    function automatic logic [5:0] prog_len(input logic [1:0] prog, input phase_t ph);
        logic [5:0] l, w, r, s;
        case (prog)
            2'd0:    begin l = P0_L; w = P0_W; r = P0_R; s = P0_S; end
            2'd1:    begin l = P1_L; w = P1_W; r = P1_R; s = P1_S; end
            2'd2:    begin l = P2_L; w = P2_W; r = P2_R; s = P2_S; end
            default: begin l = P3_L; w = P3_W; r = P3_R; s = P3_S; end
        endcase
        case (ph)
            FILL1, DRAIN1, FILL2, DRAIN2: return l;
            WASH:    return w;
            RINSE:   return r;
            SPIN:    return s;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic is_run(input phase_t ph);
        return (ph >= FILL1) && (ph <= SPIN);
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            FILL1:   return WASH;
            WASH:    return DRAIN1;
            DRAIN1:  return FILL2;
            FILL2:   return RINSE;
            RINSE:   return DRAIN2;
            DRAIN2:  return SPIN;
            SPIN:    return DONE;
            default: return ph;
        endcase
    endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Program-tick prescaler: counts only while run is high and holds its count otherwise.
module wash_tick_gen #(
    parameter int CLK_PER_TICK = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(CLK_PER_TICK - 1);

    logic [15:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= (cnt_reg == LAST) ? 16'd0 : cnt_reg + 16'd1;
        end
    end

    assign tick = run && (cnt_reg == LAST);

endmodule

// File: rtl/wash_program_ctrl.sv
// Wash-cycle sequencer: front-panel keys in, phase FSM on a prescaled tick,
// registered status bus and actuator enables out.
module wash_program_ctrl
    import wash_pkg::*;
#(
    parameter int CLK_PER_TICK = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_key,
    input  logic       start_key,
    input  logic       mode_key,
    output logic       power_off,
    output logic [3:0] counter_power,
    output logic [3:0] water_level,
    output logic [5:0] time_now,
    output logic [5:0] time_all,
    output logic       if_finish,
    output logic [3:0] phase,
    output logic       inlet_on,
    output logic       drain_on,
    output logic       motor_on
);
    phase_t     phase_reg, phase_next, saved_reg, saved_next, ph_adv;
    logic [5:0] cnt_reg, cnt_next, tn_reg, tn_next, ta_reg, ta_next, tn_dec, len_adv;
    logic [1:0] prog_reg, prog_next;
    logic [3:0] water_reg, water_next;
    logic       off_reg, off_next, fin_reg, fin_next;
    logic       inlet_reg, drain_reg, motor_reg;
    logic       tick, tick_run, tick_clear, done_entry;
    logic [5:0] time_at_done;

    // Zero-length phases keep the prescaler frozen so no tick is lost in them.
    assign tick_run   = is_run(phase_reg) && (cnt_reg != 6'd0) && !power_key && !start_key;
    assign tick_clear = (phase_reg == IDLE) && start_key && !power_key;
    assign ph_adv     = next_phase(phase_reg);
    assign len_adv    = prog_len(prog_reg, ph_adv);
    assign tn_dec     = (tn_reg != 6'd0) ? tn_reg - 6'd1 : 6'd0;

    wash_tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (tick_run),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        phase_next   = phase_reg;
        saved_next   = saved_reg;
        cnt_next     = cnt_reg;
        tn_next      = tn_reg;
        ta_next      = ta_reg;
        prog_next    = prog_reg;
        water_next   = water_reg;
        off_next     = off_reg;
        fin_next     = fin_reg;
        done_entry   = 1'b0;
        time_at_done = 6'd0;
        if (power_key) begin
            if (phase_reg == OFF) begin
                phase_next = IDLE;
                off_next   = 1'b0;
                prog_next  = 2'd0;
                ta_next    = prog_total(2'd0);
                tn_next    = prog_total(2'd0);
            end else begin
                phase_next = OFF;
                saved_next = OFF;
                off_next   = 1'b1;
                prog_next  = 2'd0;
                cnt_next   = 6'd0;
                ta_next    = 6'd0;
                tn_next    = 6'd0;
                water_next = 4'd0;
                fin_next   = 1'b0;
            end
        end else if (start_key) begin
            if (phase_reg == IDLE) begin
                phase_next = FILL1;
                cnt_next   = prog_len(prog_reg, FILL1);
            end else if (is_run(phase_reg)) begin
                phase_next = PAUSE;
                saved_next = phase_reg;
            end else if (phase_reg == PAUSE) begin
                phase_next = saved_reg;
            end else if (phase_reg == DONE) begin
                phase_next = IDLE;
                fin_next   = 1'b0;
                tn_next    = prog_total(prog_reg);
            end
        end else if (mode_key && (phase_reg == IDLE)) begin
            prog_next = prog_reg + 2'd1;
            ta_next   = prog_total(prog_reg + 2'd1);
            tn_next   = prog_total(prog_reg + 2'd1);
        end else if (is_run(phase_reg) && ((cnt_reg == 6'd0) || tick)) begin
            if (cnt_reg != 6'd0) begin
                cnt_next = cnt_reg - 6'd1;
                tn_next  = tn_dec;
                if (phase_reg == FILL1 || phase_reg == FILL2) begin
                    water_next = water_reg + 4'd1;
                end else if ((phase_reg == DRAIN1 || phase_reg == DRAIN2) && water_reg != 4'd0) begin
                    water_next = water_reg - 4'd1;
                end
            end
            if (cnt_reg <= 6'd1) begin
                phase_next = ph_adv;
                cnt_next   = len_adv;
                if (ph_adv == DONE) begin
                    done_entry   = 1'b1;
                    time_at_done = tn_next;
                    fin_next     = 1'b1;
                    tn_next      = 6'd0;
                    water_next   = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= OFF;
            saved_reg <= OFF;
            cnt_reg   <= 6'd0;
            tn_reg    <= 6'd0;
            ta_reg    <= 6'd0;
            prog_reg  <= 2'd0;
            water_reg <= 4'd0;
            off_reg   <= 1'b1;
            fin_reg   <= 1'b0;
            inlet_reg <= 1'b0;
            drain_reg <= 1'b0;
            motor_reg <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            saved_reg <= saved_next;
            cnt_reg   <= cnt_next;
            tn_reg    <= tn_next;
            ta_reg    <= ta_next;
            prog_reg  <= prog_next;
            water_reg <= water_next;
            off_reg   <= off_next;
            fin_reg   <= fin_next;
            inlet_reg <= (phase_next == FILL1) || (phase_next == FILL2);
            drain_reg <= (phase_next == DRAIN1) || (phase_next == DRAIN2) || (phase_next == SPIN);
            motor_reg <= (phase_next == WASH) || (phase_next == RINSE) || (phase_next == SPIN);
        end
    end

    // Remaining time must be used up exactly when the program completes.
    always_ff @(posedge clk) begin
        if (!reset && done_entry) begin
            assert (time_at_done == 6'd0);
        end
    end

    assign phase         = phase_reg;
    assign power_off     = off_reg;
    assign counter_power = {2'b00, prog_reg};
    assign water_level   = water_reg;
    assign time_now      = tn_reg;
    assign time_all      = ta_reg;
    assign if_finish     = fin_reg;
    assign inlet_on      = inlet_reg;
    assign drain_on      = drain_reg;
    assign motor_on      = motor_reg;

endmodule
